next_pc_btb: RTL and testbench
==============================

# next_pc_btb

Next-PC generation stage that sits directly upstream of the program counter register and drives its `jump_mux_out` input every cycle. It holds a direct-mapped branch target buffer (BTB) indexed by the current fetch PC and combines a BTB hit with the YAGS direction prediction to choose the predicted next PC. An execute-stage redirect overrides everything. Resolved control-flow instructions train the BTB on the clock edge.

## Interface
- `mem_size`, 32: address width in bits.
- `BTB_ENTRIES`, 64: number of BTB entries. Must be a power of 2 and ≥ 2. `IDX = log2(BTB_ENTRIES)`.

- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `PC_in`  in  mem_size: current fetch PC, taken from the PC register output.
- `pred_taken`  in  1: YAGS direction prediction for `PC_in`. Combinational, same cycle.
- `redirect_valid`  in  1: execute stage detected a misprediction.
- `redirect_pc`  in  mem_size: correct next PC when `redirect_valid` = 1.
- `update_valid`  in  1: a control-flow instruction resolved this cycle.
- `update_pc`  in  mem_size: PC of the resolved instruction.
- `update_target`  in  mem_size: resolved target address.
- `update_taken`  in  1: the resolved instruction was taken.
- `update_uncond`  in  1: 1 for JAL/JALR, 0 for a conditional branch.
- `jump_mux_out`  out  mem_size: next PC, driven to the PC register.
- `btb_hit`  out  1: valid entry whose tag matches `PC_in`.
- `pred_redirect`  out  1: the predicted path is used, i.e. the hit is taken and no redirect is active. Sent down the pipe for later misprediction checks.

## Operation
- Storage, one entry per index:
  - `valid` (1 bit).
  - `tag` (`mem_size-IDX-2` bits).
  - `target` (`mem_size-2` bits; the low 2 bits are implied 00).
  - `uncond` (1 bit).
- Lookup address split: index = `PC_in[IDX+1:2]`, tag = `PC_in[mem_size-1:IDX+2]`.
- Lookup is combinational and reads the registered arrays.
- `btb_hit` = valid[index] && tag match.
- Taken-hit = `btb_hit` && (uncond[index] || `pred_taken`).
- `jump_mux_out` priority, highest first:
  1. `redirect_valid` → `redirect_pc`, passed through unmodified.
  2. taken-hit → {target[index], 2'b00}.
  3. otherwise → `PC_in + 4`, modulo 2^mem_size. For example, 0xFFFFFFFC wraps to 0x00000000.
- `pred_redirect` = taken-hit && !`redirect_valid`.
- Update, on the rising edge when `update_valid` = 1, using index and tag taken from `update_pc`:
  - `update_taken` = 1: write the entry with valid = 1, tag, `update_target[mem_size-1:2]` and `update_uncond`. Any previous occupant of that index is overwritten (direct-mapped replacement).
  - `update_taken` = 0 and the entry hits on `update_pc`: if `update_uncond` = 0, clear valid. This is a repeated not-taken, so free the slot. If `update_uncond` = 1 the combination is illegal; leave the entry unchanged.
  - `update_taken` = 0 and no hit: no change.
- `update_target[1:0]` is discarded.
- The `pred_taken` value is never stored. Direction stays the YAGS block's job.
- The block has no notion of a PC stall. When the PC register holds, `PC_in` is unchanged and the outputs stay stable. Updates still apply during a stall.

## Timing
- Lookup path: zero latency, combinational from `PC_in`, `pred_taken` and `redirect_*` to the outputs.
- Update: one cycle. An entry written at edge N is visible to lookup from after edge N.
- Update and lookup to the same index in the same cycle: the lookup sees the pre-update contents. No write bypass.
- Redirect and update in the same cycle: both take effect. The redirect steers the output; the update writes the BTB.
- Reset (asynchronous, `reset` = 0):
  - All valid bits clear immediately, mid-operation included.
  - Tag, target and uncond bits need no reset.
  - During reset and afterwards, until the first update: `btb_hit` = 0, `pred_redirect` = 0, and `jump_mux_out` = `PC_in + 4` (or `redirect_pc` if `redirect_valid` = 1).
- The first update is accepted on the first rising edge after `reset` deasserts.

## Test plan
- Reset, then `PC_in` = 0x00000000 → `jump_mux_out` = 0x00000004, `btb_hit` = 0. Then `PC_in` = 0xFFFFFFFC → `jump_mux_out` = 0x00000000.
- Update `update_pc` = 0x100, target 0x200, taken, uncond = 0. Next cycle `PC_in` = 0x100:
  - `pred_taken` = 1 → `jump_mux_out` = 0x200, `pred_redirect` = 1.
  - `pred_taken` = 0 → 0x104.
- Update 0x100 → 0x300 with uncond = 1 → `jump_mux_out` = 0x300 regardless of `pred_taken`. Then update 0x100 + 4·`BTB_ENTRIES` (same index, different tag) taken → lookup at 0x100 misses.
- Redirect priority: with an entry for 0x100, `PC_in` = 0x100 and `redirect_valid` = 1, `redirect_pc` = 0x440 → `jump_mux_out` = 0x440, `pred_redirect` = 0.
- Conditional entry at 0x100 followed by a not-taken update for 0x100 → next-cycle lookup at 0x100 misses, output 0x104. Same-cycle update and lookup at 0x100 → the old target is still used that cycle.
- Several entries valid; assert `reset` low between clock edges → `btb_hit` falls immediately, with no clock edge needed. After release, all lookups miss.

Source files
------------

// File: rtl/next_pc_btb.sv
// rtl/next_pc_btb.sv - next-PC select with a direct-mapped branch target buffer
module next_pc_btb #(
    parameter int mem_size    = 32,
    parameter int BTB_ENTRIES = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [mem_size-1:0] PC_in,
    input  logic                pred_taken,
    input  logic                redirect_valid,
    input  logic [mem_size-1:0] redirect_pc,
    input  logic                update_valid,
    input  logic [mem_size-1:0] update_pc,
    input  logic [mem_size-1:0] update_target,
    input  logic                update_taken,
    input  logic                update_uncond,
    output logic [mem_size-1:0] jump_mux_out,
    output logic                btb_hit,
    output logic                pred_redirect
);
    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = mem_size - IDX - 2;
    localparam int TGT_W = mem_size - 2;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [BTB_ENTRIES-1:0] uncond_q;
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [TGT_W-1:0]       target_q [BTB_ENTRIES];

    logic [IDX-1:0]   look_idx;
    logic [TAG_W-1:0] look_tag;
    logic             taken_hit;
    logic [IDX-1:0]   upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             unused_target_bits;

    assign look_idx = PC_in[IDX+1:2];
    assign look_tag = PC_in[mem_size-1:IDX+2];
    assign upd_idx  = update_pc[IDX+1:2];
    assign upd_tag  = update_pc[mem_size-1:IDX+2];

    // Targets are word aligned, so the low two bits are never stored.
    assign unused_target_bits = ^update_target[1:0];

    assign btb_hit   = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
    assign taken_hit = btb_hit && (uncond_q[look_idx] || pred_taken);
    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    assign pred_redirect = taken_hit && !redirect_valid;

    always_comb begin
        jump_mux_out = PC_in + mem_size'(4);
        if (redirect_valid) begin
            jump_mux_out = redirect_pc;
        end else if (taken_hit) begin
            jump_mux_out = {target_q[look_idx], 2'b00};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (update_valid) begin
            if (update_taken) begin
                valid_q[upd_idx] <= 1'b1;
            end else if (upd_hit && !update_uncond) begin
                // A not-taken conditional frees its slot; a not-taken jump is ignored.
                valid_q[upd_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (update_valid && update_taken) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= update_target[mem_size-1:2];
            uncond_q[upd_idx] <= update_uncond;
        end
    end
endmodule

// File: tb/tb_next_pc_btb.sv
// tb/tb_next_pc_btb.sv - randomized model-checked bench for next_pc_btb
module tb_next_pc_btb;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] PC_in = 32'h0;
    logic        pred_taken = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        update_valid = 1'b0;
    logic [31:0] update_pc = 32'h0;
    logic [31:0] update_target = 32'h0;
    logic        update_taken = 1'b0;
    logic        update_uncond = 1'b0;
    logic [31:0] jump_mux_out;
    logic        btb_hit;
    logic        pred_redirect;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    // Model: per slot, the full PC of the branch that owns it and its target.
    bit          mvalid [64];
    logic [31:0] mpc    [64];
    logic [31:0] mtgt   [64];
    bit          munc   [64];

    next_pc_btb #(.mem_size(32), .BTB_ENTRIES(64)) dut (
        .clk(clk), .reset(reset), .PC_in(PC_in), .pred_taken(pred_taken),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .update_valid(update_valid), .update_pc(update_pc),
        .update_target(update_target), .update_taken(update_taken),
        .update_uncond(update_uncond), .jump_mux_out(jump_mux_out),
        .btb_hit(btb_hit), .pred_redirect(pred_redirect)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit model_hit(input logic [31:0] pc);
        int i;
        i = int'((pc / 4) % 64);
        return mvalid[i] && ((mpc[i] / 4) == (pc / 4));
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
        end else if (update_valid) begin
            int i;
            i = int'((update_pc / 4) % 64);
            if (update_taken) begin
                mvalid[i] = 1'b1;
                mpc[i]    = update_pc;
                mtgt[i]   = update_target;
                munc[i]   = update_uncond;
            end else if (model_hit(update_pc) && !update_uncond) begin
                mvalid[i] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            int i;
            bit hit;
            bit th;
            logic [31:0] exp_j;
            i     = int'((PC_in / 4) % 64);
            hit   = model_hit(PC_in);
            th    = hit && (munc[i] || pred_taken);
            exp_j = redirect_valid ? redirect_pc : (th ? (mtgt[i] & 32'hFFFF_FFFC) : PC_in + 32'd4);
            chk("model_jump", jump_mux_out, exp_j);
            chk("model_hit", {31'b0, btb_hit}, {31'b0, hit});
            chk("model_pred_redirect", {31'b0, pred_redirect}, {31'b0, th && !redirect_valid});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input bit tk, input bit un);
        update_valid  = 1'b1;
        update_pc     = pc;
        update_target = tgt;
        update_taken  = tk;
        update_uncond = un;
    endtask

    function automatic logic [31:0] pool_pc();
        if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
        return 32'h1000 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 2)) * 256;
    endfunction

    initial begin
        cyc(); cyc();
        cmp_en = 1'b1;
        PC_in = 32'h0; #1;
        chk("reset_jump", jump_mux_out, 32'h4);
        chk("reset_hit", {31'b0, btb_hit}, 32'h0);
        cyc(); reset = 1'b1;
        PC_in = 32'hFFFF_FFFC; #1;
        chk("wrap", jump_mux_out, 32'h0);

        cyc(); upd(32'h100, 32'h200, 1, 0); PC_in = 32'h0;
        cyc(); update_valid = 1'b0; PC_in = 32'h100; pred_taken = 1'b1; #1;
        chk("cond_taken", jump_mux_out, 32'h200);
        chk("cond_pred_redirect", {31'b0, pred_redirect}, 32'h1);
        pred_taken = 1'b0; #1;
        chk("cond_not_taken", jump_mux_out, 32'h104);

        cyc(); upd(32'h100, 32'h300, 1, 1);
        cyc(); update_valid = 1'b0; pred_taken = 1'b0; #1;
        chk("uncond_pt0", jump_mux_out, 32'h300);
        pred_taken = 1'b1; #1;
        chk("uncond_pt1", jump_mux_out, 32'h300);
        redirect_valid = 1'b1; redirect_pc = 32'h440; #1;
        chk("redirect_jump", jump_mux_out, 32'h440);
        chk("redirect_pred", {31'b0, pred_redirect}, 32'h0);
        redirect_valid = 1'b0;

        cyc(); upd(32'h200, 32'h500, 1, 0);
        cyc(); update_valid = 1'b0; PC_in = 32'h100; #1;
        chk("alias_miss", {31'b0, btb_hit}, 32'h0);
        chk("alias_jump", jump_mux_out, 32'h104);

        cyc(); upd(32'h100, 32'h600, 1, 0);
        cyc(); upd(32'h100, 32'h0, 0, 0); pred_taken = 1'b1; #1;
        chk("same_cycle_old", jump_mux_out, 32'h600);
        cyc(); update_valid = 1'b0; #1;
        chk("freed_jump", jump_mux_out, 32'h104);

        cyc(); upd(32'h100, 32'h703, 1, 1);
        cyc(); upd(32'h100, 32'h0, 0, 1);
        cyc(); update_valid = 1'b0; pred_taken = 1'b0; #1;
        chk("illegal_kept", jump_mux_out, 32'h700);

        for (int n = 0; n < 3000; n++) begin
            cyc();
            PC_in          = pool_pc();
            pred_taken     = 1'($urandom_range(0, 1));
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_pc    = $urandom;
            update_valid   = 1'($urandom_range(0, 1));
            update_pc      = pool_pc();
            update_target  = $urandom;
            update_taken   = ($urandom_range(0, 2) != 0);
            update_uncond  = ($urandom_range(0, 3) == 0);
        end

        cyc(); redirect_valid = 1'b0; upd(32'h100, 32'h800, 1, 1);
        cyc(); upd(32'h104, 32'h900, 1, 1);
        cyc(); upd(32'h108, 32'hA00, 1, 0);
        cyc(); update_valid = 1'b0; PC_in = 32'h104; #1;
        chk("pre_reset_hit", {31'b0, btb_hit}, 32'h1);
        #1; reset = 1'b0; #1;
        chk("async_reset_hit", {31'b0, btb_hit}, 32'h0);
        chk("async_reset_jump", jump_mux_out, 32'h108);
        cyc(); reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc(); PC_in = 32'h100 + 32'(k) * 4; pred_taken = 1'b1; #1;
            chk("post_reset_miss", {31'b0, btb_hit}, 32'h0);
        end
        cyc();
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
